cdc_fifo_stream_reader: RTL and testbench

Read-domain consumer for the CDC FIFO's receiver port. It drains words through the FIFO's `empty` / `read_increment` / `read_data` interface and presents them as a registered valid/ready stream, using a 2-entry output buffer. It also frames the stream into fixed-length packets, counts delivered words, and supports a flush that discards buffered and queued data. It sits in the `read_clock` domain between the FIFO and the downstream consumer.

---
 rtl/cdc_fifo_stream_reader_if.sv | 51 +++++
 rtl/cdc_fifo_stream_reader.sv | 153 +++++++++++++++
 tb/tb_cdc_fifo_stream_reader.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_stream_reader_if.sv
// Bundle of FIFO read-port, output stream and flush/status signals for the stream reader.
interface cdc_fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned COUNT_WIDTH = 16
);

  // FIFO receiver port (show-ahead)
  logic                   fifo_empty;
  logic [DATA_WIDTH-1:0]  fifo_read_data;
  logic                   fifo_read_increment;

  // Downstream valid/ready stream
  logic [DATA_WIDTH-1:0]  out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_last;

  // Flush control and status
  logic                   flush;
  logic                   flushing;
  logic [COUNT_WIDTH-1:0] delivered_count;

  // Reader side: consumes FIFO words, produces the stream
  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    input  out_ready,
    input  flush,
    output fifo_read_increment,
    output out_data,
    output out_valid,
    output out_last,
    output flushing,
    output delivered_count
  );

  // Environment side: FIFO plus downstream consumer
  modport slave (
    output fifo_empty,
    output fifo_read_data,
    output out_ready,
    output flush,
    input  fifo_read_increment,
    input  out_data,
    input  out_valid,
    input  out_last,
    input  flushing,
    input  delivered_count
  );

endinterface

// File: rtl/cdc_fifo_stream_reader.sv
// Read-domain FIFO drain: 2-entry skid buffer to a registered valid/ready stream,
// fixed-length packet framing, saturating delivered-word counter and flush.
module cdc_fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PACKET_LENGTH = 16,
  parameter int unsigned COUNT_WIDTH   = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  cdc_fifo_stream_reader_if.master bus
);

  localparam int unsigned IDX_W = (PACKET_LENGTH > 1) ? $clog2(PACKET_LENGTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PACKET_LENGTH - 1);

  typedef enum logic {
    ST_STREAM = 1'b0,
    ST_FLUSH  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             occ_q, occ_d;
  logic [DATA_WIDTH-1:0]  head_q, head_d;
  logic [DATA_WIDTH-1:0]  skid_q, skid_d;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  logic pop_c;
  logic xfer_c;
  logic flushing_c;

  assign xfer_c = valid_q && bus.out_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_STREAM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: flush request enters FLUSH, first observed empty leaves it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STREAM: if (bus.flush)      state_d = ST_FLUSH;
      ST_FLUSH:  if (bus.fifo_empty) state_d = ST_STREAM;
      default:                       state_d = ST_STREAM;
    endcase
  end

  // FSM outputs: pop only from a non-empty FIFO, never while held in reset
  always_comb begin
    pop_c      = 1'b0;
    flushing_c = 1'b0;
    case (state_q)
      ST_STREAM: pop_c = !bus.fifo_empty && (occ_q < 2'd2);
      ST_FLUSH: begin
        pop_c      = !bus.fifo_empty;
        flushing_c = 1'b1;
      end
      default: pop_c = 1'b0;
    endcase
    if (reset) pop_c = 1'b0;
  end

  // Buffer, packet index and counter next-state
  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    idx_d  = idx_q;
    cnt_d  = cnt_q;

    // A transfer always completes, even in the cycle a flush is requested
    if (xfer_c) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end

    if (state_q == ST_FLUSH) begin
      // Popped words are dropped; buffer stays empty
      occ_d = 2'd0;
    end else if (bus.flush) begin
      // Discard buffered words and any word popped this cycle
      occ_d = 2'd0;
      idx_d = '0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (pop_c) begin
            head_d = bus.fifo_read_data;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          case ({xfer_c, pop_c})
            2'b11: head_d = bus.fifo_read_data;
            2'b10: occ_d  = 2'd0;
            2'b01: begin
              skid_d = bus.fifo_read_data;
              occ_d  = 2'd2;
            end
            default: occ_d = occ_q;
          endcase
        end
        2'd2: begin
          // Full: no pop possible; a transfer promotes the skid entry
          if (xfer_c) begin
            head_d = skid_q;
            occ_d  = 2'd1;
          end
        end
        default: occ_d = 2'd0;
      endcase
    end

    valid_d = (occ_d != 2'd0);
    last_d  = valid_d && (idx_d == IDX_LAST);
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ_q   <= 2'd0;
      head_q  <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fifo_read_increment = pop_c;
  assign bus.out_data            = head_q;
  assign bus.out_valid           = valid_q;
  assign bus.out_last            = last_q;
  assign bus.flushing            = flushing_c;
  assign bus.delivered_count     = cnt_q;

endmodule

// File: tb/tb_cdc_fifo_stream_reader.sv
// Bench for cdc_fifo_stream_reader: queue-modelled show-ahead FIFO, data scoreboard,
// cycle table for streaming/backpressure, hand sequences for flush, saturation and reset.
module tb_cdc_fifo_stream_reader;

  localparam int unsigned DW = 8;
  localparam int unsigned PL = 4;
  localparam int unsigned CW = 4;
  localparam int          CNT_MAX = 15;
  localparam int          NV = 15;

  typedef struct {
    int unsigned npush;
    logic [7:0]  base;
    logic [7:0]  stride;
    logic        ready;
    logic        ev;
    logic [7:0]  ed;
    logic        el;
    logic        ei;
    int          ec;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  cdc_fifo_stream_reader_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  cdc_fifo_stream_reader #(
    .DATA_WIDTH   (DW),
    .PACKET_LENGTH(PL),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         m_idx = 0;
  int         m_cnt = 0;
  int         checks = 0;
  int         failures = 0;
  int         pops = 0;
  logic       pend = 1'b0;
  vec_t       vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_fifo();
    bus.fifo_empty     = (fifo_q.size() == 0);
    bus.fifo_read_data = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    drive_fifo();
  endtask

  // Falling edge: invariants, scoreboard compare for a transfer, latch pop decision
  task automatic at_neg();
    logic [7:0] e;
    @(negedge clock);
    chk("pop_while_empty", 32'(bus.fifo_read_increment && bus.fifo_empty), 32'd0);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_xfer actual=0x%0h required=no_transfer", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("xfer_data", 32'(bus.out_data), 32'(e));
        chk("xfer_last", 32'(bus.out_last), 32'(m_idx == int'(PL) - 1));
        m_idx = (m_idx == int'(PL) - 1) ? 0 : m_idx + 1;
        if (m_cnt < CNT_MAX) m_cnt++;
      end
    end
    pend = bus.fifo_read_increment;
  endtask

  // Rising edge: apply the FIFO pop seen by the DUT, end any flush pulse
  task automatic at_pos();
    @(posedge clock);
    #1;
    if (pend && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
      drive_fifo();
    end
    pend = 1'b0;
    bus.flush = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40; k++) begin
      if (exp_q.size() == 0) break;
      at_neg();
      at_pos();
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fl_cycles;

    //           npush base   stride ready ev  ed     el ei ec
    vecs[0]  = '{3, 8'h11, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 0};
    vecs[1]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 0};
    vecs[2]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1};
    vecs[3]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 2};
    vecs[4]  = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 3};
    vecs[5]  = '{5, 8'hA0, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 3};
    vecs[6]  = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 3};
    vecs[7]  = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 3};
    vecs[8]  = '{0, 8'h00, 8'h00, 1'b0, 1'b1, 8'hA0, 1'b1, 1'b0, 3};
    vecs[9]  = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA0, 1'b1, 1'b0, 3};
    vecs[10] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 4};
    vecs[11] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 5};
    vecs[12] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b1, 6};
    vecs[13] = '{0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hA4, 1'b1, 1'b0, 7};
    vecs[14] = '{0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8};

    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    drive_fifo();

    // Reset values
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    chk("rst_inc", 32'(bus.fifo_read_increment), 32'd0);
    chk("rst_flushing", 32'(bus.flushing), 32'd0);
    chk("rst_count", 32'(bus.delivered_count), 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Streaming and backpressure, cycle by cycle
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < int'(vecs[i].npush); k++)
        push(8'(int'(vecs[i].base) + k * int'(vecs[i].stride)));
      bus.out_ready = vecs[i].ready;
      at_neg();
      chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
      if (vecs[i].ev) chk($sformatf("v%0d_data", i), 32'(bus.out_data), 32'(vecs[i].ed));
      chk($sformatf("v%0d_last", i), 32'(bus.out_last), 32'(vecs[i].el));
      chk($sformatf("v%0d_inc", i), 32'(bus.fifo_read_increment), 32'(vecs[i].ei));
      chk($sformatf("v%0d_count", i), 32'(bus.delivered_count), 32'(vecs[i].ec));
      at_pos();
    end

    // Flush with a full buffer and three words still queued
    bus.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(8'(8'h60 + k));
    for (int k = 0; k < 4; k++) begin
      at_neg();
      at_pos();
    end
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    at_neg();
    chk("fl_head_valid", 32'(bus.out_valid), 32'd1);
    chk("fl_head_data", 32'(bus.out_data), 32'h60);
    chk("fl_fifo_left", 32'(fifo_q.size()), 32'd3);
    at_pos();
    exp_q.delete();
    m_idx     = 0;
    pops      = 0;
    fl_cycles = 0;
    for (int k = 0; k < 10; k++) begin
      at_neg();
      if (!bus.flushing) break;
      fl_cycles++;
      chk("fl_valid_low", 32'(bus.out_valid), 32'd0);
      at_pos();
    end
    chk("fl_cycles", 32'(fl_cycles), 32'd4);
    chk("fl_pops", 32'(pops), 32'd3);
    chk("fl_fifo_empty", 32'(fifo_q.size()), 32'd0);
    chk("fl_count", 32'(bus.delivered_count), 32'd9);
    chk("fl_after_valid", 32'(bus.out_valid), 32'd0);
    at_pos();

    // Framing from index 0 and counter saturation: 10 words, last on 4th and 8th
    for (int k = 0; k < 10; k++) push(8'(8'h40 + k));
    drain("frame_drain");
    at_neg();
    chk("sat_count", 32'(bus.delivered_count), 32'(CNT_MAX));
    at_pos();

    // Full buffer, FIFO refills: no pop; then async reset mid-stream
    bus.out_ready = 1'b0;
    push(8'h80);
    push(8'h81);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      at_pos();
    end
    push(8'h82);
    push(8'h83);
    at_neg();
    chk("full_no_pop", 32'(bus.fifo_read_increment), 32'd0);
    chk("full_valid", 32'(bus.out_valid), 32'd1);
    chk("full_data", 32'(bus.out_data), 32'h80);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_data", 32'(bus.out_data), 32'd0);
    chk("arst_last", 32'(bus.out_last), 32'd0);
    chk("arst_inc", 32'(bus.fifo_read_increment), 32'd0);
    chk("arst_count", 32'(bus.delivered_count), 32'd0);
    pend = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    foreach (fifo_q[k]) exp_q.push_back(fifo_q[k]);
    m_idx = 0;
    m_cnt = 0;
    bus.out_ready = 1'b1;
    drain("rst_drain");
    at_neg();
    chk("rst_resume_count", 32'(bus.delivered_count), 32'd2);
    at_pos();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
